// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//  Types and constants shared by the team's synchronous FIFO and the
//  blocks that sit on its read/write sides.
//   FIFO_DW      : native FIFO data width
//   fifo_word_t  : one FIFO word
//   occ_width()  : bits needed to count 0..depth entries
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DW = 16;

    typedef logic [FIFO_DW-1:0] fifo_word_t;

    // A buffer of 'depth' entries must be able to represent both 0 and depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// ---------------------------------------------------------------------------
// stream_skid_buf
//  Small circular buffer with push/pop and a zero-latency head view.
//  The head word comes straight out of registered storage, so a consumer
//  sees a stable value for as long as it does not pop.
//  Storage is cleared on reset so the head view reads zero out of reset.
// Ports
//  clk          rising-edge clock
//  rst          synchronous active-high reset (empties the buffer)
//  i_push       write i_push_data at the tail
//  i_push_data  word to store
//  i_pop        drop the head entry (ignored when empty)
//  o_head_data  current head entry
//  o_occ        number of stored entries, 0..SKID_DEPTH
// SKID_DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DW         = FIFO_DW,
    parameter int SKID_DEPTH = 4,
    localparam int OCC_W     = occ_width(SKID_DEPTH),
    localparam int PTR_W     = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [DW-1:0]    i_push_data,
    input  logic             i_pop,
    output logic [DW-1:0]    o_head_data,
    output logic [OCC_W-1:0] o_occ
);

    logic [DW-1:0]    r_mem [SKID_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             w_pop;

    // Pointers wrap at SKID_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Popping an empty buffer is a no-op rather than an underflow.
    assign w_pop = i_pop && (r_occ != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_tail] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            // The upstream credit check guarantees room for every push.
            assert (!(i_push && (r_occ == OCC_W'(SKID_DEPTH))));
            if (i_push) begin
                r_tail <= f_next(r_tail);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end
            r_occ <= r_occ + OCC_W'(i_push) - OCC_W'(w_pop);
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//  Read-side controller for the synchronous FIFO. Issues re strobes, absorbs
//  the FIFO's one-cycle read latency and presents words on a valid/ready
//  stream. A skid buffer lets reads run ahead of the consumer so that
//  fifo_re never depends combinationally on m_ready.
// Ports
//  clk         rising-edge clock
//  rst         synchronous active-high reset
//  en          1 = reads may be issued
//  fifo_empty  FIFO empty flag
//  fifo_dout   FIFO read data, valid the cycle after fifo_re
//  fifo_re     FIFO read strobe
//  m_valid     stream word available
//  m_ready     consumer accepts word
//  m_data      stream word
//  words_out   handshake count, wraps modulo 2^CNT_W
//  idle        FIFO empty, no read in flight, nothing buffered
// ---------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DW         = FIFO_DW,
    parameter int SKID_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_re,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] words_out,
    output logic             idle
);

    localparam int OCC_W = occ_width(SKID_DEPTH);

    logic             r_inflight;
    logic [CNT_W-1:0] r_words_out;
    logic [OCC_W-1:0] w_occ;
    logic             w_credit;
    logic             w_pop;

    // A read is only issued when its word is guaranteed a slot: entries
    // already stored plus the word still coming out of the FIFO must leave
    // room. Using registered occupancy keeps m_ready out of this path.
    assign w_credit = (int'(w_occ) + int'(r_inflight)) < SKID_DEPTH;
    assign fifo_re  = en && !fifo_empty && !rst && w_credit;

    assign m_valid  = (w_occ != '0);
    assign w_pop    = m_valid && m_ready;

    // fifo_dout is only meaningful the cycle after a read; the in-flight
    // flag is what gates the push, so idle-cycle garbage is never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_words_out <= '0;
        end else begin
            r_inflight <= fifo_re;
            if (w_pop) begin
                r_words_out <= r_words_out + CNT_W'(1);
            end
        end
    end

    stream_skid_buf #(
        .DW         (DW),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_dout),
        .i_pop       (w_pop),
        .o_head_data (m_data),
        .o_occ       (w_occ)
    );

    assign words_out = r_words_out;
    assign idle      = fifo_empty && !r_inflight && !m_valid;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             fifo_empty;
    logic [DW-1:0]    fifo_dout;
    logic             fifo_re;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [CNT_W-1:0] words_out;
    logic             idle;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DW         (DW),
        .SKID_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .words_out  (words_out),
        .idle       (idle)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Environment: FIFO contents and control knobs
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_all[$];
    logic [DW-1:0] exp_list[$];
    logic [DW-1:0] delivered[$];
    logic [DW-1:0] dout_next;
    bit            force_empty, en_v, rdy_v, rst_v;

    // Reference model: what the stream should hold, as a plain queue
    logic [DW-1:0] mdl_q[$];
    bit            mdl_infl;
    logic [DW-1:0] mdl_infl_word;
    int            mdl_cnt;
    bit            mdl_known, prev_rst;

    int reads_done, cyc, first_re_cyc, first_val_cyc;

    // One clock cycle: drive at negedge, check mid-cycle, advance at posedge.
    task automatic step();
        bit exp_re, re_obs;
        @(negedge clk);
        rst        = rst_v;
        en         = en_v;
        m_ready    = rdy_v;
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        fifo_dout  = dout_next;
        #1;
        exp_re = en_v && !fifo_empty && !rst_v && ((mdl_q.size() + int'(mdl_infl)) < DEPTH);
        check_eq("fifo_re", 32'(fifo_re), 32'(exp_re));
        if (mdl_known) begin
            check_eq("m_valid", 32'(m_valid), 32'(mdl_q.size() > 0));
            if (mdl_q.size() > 0) check_eq("m_data", 32'(m_data), 32'(mdl_q[0]));
            if (prev_rst) check_eq("m_data_rst", 32'(m_data), 32'h0);
            check_eq("words_out", 32'(words_out), 32'(mdl_cnt % (1 << CNT_W)));
            check_eq("idle", 32'(idle),
                     32'(fifo_empty && !mdl_infl && (mdl_q.size() == 0)));
        end
        if (m_valid && m_ready && !rst_v) delivered.push_back(m_data);
        if (m_valid && !rst_v && first_val_cyc < 0) first_val_cyc = cyc;
        if (exp_re) begin
            reads_done++;
            if (first_re_cyc < 0) first_re_cyc = cyc;
        end
        re_obs = fifo_re;
        @(posedge clk);
        // model advance
        if (rst_v) begin
            mdl_q.delete();
            mdl_infl  = 1'b0;
            mdl_cnt   = 0;
            mdl_known = 1'b1;
        end else begin
            if ((mdl_q.size() > 0) && rdy_v) begin
                void'(mdl_q.pop_front());
                mdl_cnt++;
            end
            if (mdl_infl) mdl_q.push_back(mdl_infl_word);
            mdl_infl = exp_re;
            if (exp_re && fifo_q.size() > 0) mdl_infl_word = fifo_q[0];
        end
        prev_rst = rst_v;
        // FIFO: a read presents the head word next cycle, otherwise garbage
        if (re_obs && !force_empty && fifo_q.size() > 0) dout_next = fifo_q.pop_front();
        else dout_next = 16'($urandom);
        cyc++;
    endtask

    // mode 0 stream, 1 backpressure, 2 empty mid-stream, 3 reset mid-burst,
    // 4 en drop after 2 reads, 5 random soak
    task automatic run_scenario(input int mode, input int nwords, input int ncycles);
        int n;
        fifo_q.delete();
        exp_all.delete();
        exp_list.delete();
        delivered.delete();
        for (int i = 0; i < nwords; i++) begin
            logic [DW-1:0] w;
            w = (mode <= 1) ? 16'(i + 1) : 16'($urandom);
            fifo_q.push_back(w);
            exp_all.push_back(w);
        end
        force_empty = 1'b0;
        en_v        = 1'b1;
        rdy_v       = 1'b1;
        rst_v       = 1'b1;
        repeat (3) step();
        rst_v         = 1'b0;
        reads_done    = 0;
        cyc           = 0;
        first_re_cyc  = -1;
        first_val_cyc = -1;
        for (int c = 0; c < ncycles; c++) begin
            case (mode)
                1: rdy_v = (c >= 10);
                2: force_empty = (reads_done >= 2);
                3: begin
                    rdy_v = (c > 3);
                    rst_v = (c == 3);
                end
                4: en_v = (reads_done < 2);
                5: begin
                    if (c < ncycles - 60) begin
                        en_v        = ($urandom_range(0, 1) == 1);
                        rdy_v       = ($urandom_range(0, 3) != 0);
                        force_empty = ($urandom_range(0, 3) == 0);
                    end else begin
                        en_v        = 1'b1;
                        rdy_v       = 1'b1;
                        force_empty = 1'b0;
                    end
                end
                default: ;
            endcase
            step();
        end
        case (mode)
            2, 4: for (int i = 0; i < 2; i++) exp_list.push_back(exp_all[i]);
            3: for (int i = 3; i < exp_all.size(); i++) exp_list.push_back(exp_all[i]);
            default: exp_list = exp_all;
        endcase
        #1;
        check_eq("n_delivered", 32'(delivered.size()), 32'(exp_list.size()));
        n = (delivered.size() < exp_list.size()) ? delivered.size() : exp_list.size();
        for (int i = 0; i < n; i++) check_eq("order", 32'(delivered[i]), 32'(exp_list[i]));
        check_eq("words_final", 32'(words_out), 32'(exp_list.size() % (1 << CNT_W)));
        if (mode == 0) check_eq("latency", 32'(first_val_cyc - first_re_cyc), 32'd2);
        if (mode == 0 || mode == 1 || mode == 5) check_eq("idle_end", 32'(idle), 32'd1);
        $display("scenario mode=%0d words=%0d delivered=%0d checks=%0d", mode, nwords,
                 delivered.size(), n_checks);
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        dout_next  = 16'($urandom);
        mdl_known  = 1'b0;
        prev_rst   = 1'b0;
        mdl_infl   = 1'b0;
        mdl_cnt    = 0;
        run_scenario(0, 5, 12);
        run_scenario(1, 8, 30);
        run_scenario(2, 6, 15);
        run_scenario(3, 8, 25);
        run_scenario(0, 17, 25);
        run_scenario(4, 6, 15);
        for (int k = 0; k < 3; k++) run_scenario(5, 40, 220);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
